// File: rtl/tone_period_decoder.sv
// Tone period decoder: measures, locks onto and tracks the period of a
// 1-bit square-wave audio stream, and flags silence between notes.
module tone_period_decoder #(
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned MIN_PERIOD     = 16,
  parameter int unsigned TOLERANCE      = 2,
  parameter int unsigned STABLE_PERIODS = 2,
  parameter int unsigned SILENCE_CYCLES = 50000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 audio_in,
  output logic [CNT_WIDTH-1:0] period_out,
  output logic                 period_valid,
  output logic                 locked,
  output logic                 silence
);

  localparam int unsigned MATCH_W = (STABLE_PERIODS < 1) ? 1 : $clog2(STABLE_PERIODS + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACQUIRE = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MIN = CNT_WIDTH'(MIN_PERIOD);
  localparam logic [CNT_WIDTH-1:0] CNT_SIL = CNT_WIDTH'(SILENCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_SM1 = CNT_WIDTH'(SILENCE_CYCLES - 1);
  localparam logic [CNT_WIDTH:0]   TOL_W   = (CNT_WIDTH + 1)'(TOLERANCE);
  localparam logic [MATCH_W-1:0]   M_ONE   = MATCH_W'(1);
  localparam logic [MATCH_W-1:0]   M_LOCK  = MATCH_W'(STABLE_PERIODS);

  logic                 sync1, sync2, prev;
  logic [1:0]           fill;
  logic                 edge_c, accept_c, last_hit_c, lock_hit_c;
  logic [MATCH_W-1:0]   match_new_c;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] counter_q, counter_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [CNT_WIDTH-1:0] last_q, last_d;
  logic [CNT_WIDTH-1:0] period_d;
  logic                 locked_d, valid_d, silence_d;

  // Unsigned absolute difference one bit wider than the operands so it never wraps.
  function automatic logic [CNT_WIDTH:0] absdiff(input logic [CNT_WIDTH-1:0] a,
                                                 input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[CNT_WIDTH] ? ({1'b0, b} - {1'b0, a}) : d;
  endfunction

  // Two-flop synchronizer plus previous-value flop; fill arms edge detection
  // only once sync2 and prev both hold real samples taken after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      fill  <= 2'd0;
    end else begin
      sync1 <= audio_in;
      sync2 <= sync1;
      prev  <= sync2;
      if (fill != 2'd3) fill <= fill + 2'd1;
    end
  end

  // Edge qualification and period comparisons against the current counter value.
  assign edge_c      = (fill == 2'd3) && sync2 && !prev;
  assign accept_c    = edge_c && (counter_q >= CNT_MIN);
  assign last_hit_c  = (last_q != '0) && (absdiff(counter_q, last_q) <= TOL_W);
  assign lock_hit_c  = absdiff(counter_q, period_out) <= TOL_W;
  assign match_new_c = last_hit_c ? (match_q + M_ONE) : '0;

  // State register and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      counter_q    <= '0;
      match_q      <= '0;
      last_q       <= '0;
      period_out   <= '0;
      locked       <= 1'b0;
      period_valid <= 1'b0;
      silence      <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      match_q      <= match_d;
      last_q       <= last_d;
      period_out   <= period_d;
      locked       <= locked_d;
      period_valid <= valid_d;
      silence      <= silence_d;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d   = state_q;
    counter_d = (counter_q >= CNT_SIL) ? CNT_SIL : (counter_q + CNT_ONE);
    match_d   = match_q;
    last_d    = last_q;
    period_d  = period_out;
    locked_d  = locked;
    valid_d   = 1'b0;
    silence_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (edge_c) begin
          counter_d = CNT_ONE;
          match_d   = '0;
          last_d    = '0;
          state_d   = S_ACQUIRE;
        end
      end

      S_ACQUIRE: begin
        if (accept_c) begin
          counter_d = CNT_ONE;
          last_d    = counter_q;
          match_d   = match_new_c;
          if (match_new_c == M_LOCK) begin
            state_d  = S_LOCKED;
            period_d = counter_q;
            locked_d = 1'b1;
            valid_d  = 1'b1;
          end
        end else if (counter_q == CNT_SM1) begin
          state_d   = S_IDLE;
          match_d   = '0;
          period_d  = '0;
          locked_d  = 1'b0;
          silence_d = 1'b1;
        end
      end

      S_LOCKED: begin
        if (accept_c) begin
          counter_d = CNT_ONE;
          if (!lock_hit_c) begin
            state_d  = S_ACQUIRE;
            locked_d = 1'b0;
            period_d = '0;
            last_d   = counter_q;
            match_d  = '0;
          end
        end else if (counter_q == CNT_SM1) begin
          state_d   = S_IDLE;
          match_d   = '0;
          period_d  = '0;
          locked_d  = 1'b0;
          silence_d = 1'b1;
        end
      end

      default: begin
        state_d  = S_IDLE;
        period_d = '0;
        locked_d = 1'b0;
      end
    endcase
  end

endmodule
